// File: rtl/uart_pkg.sv
// uart_pkg: types, line constants and the parity helper shared by the UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PARITY,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  // Widest data word the parity helper accepts; narrower words are zero-padded,
  // which leaves the reduction unchanged.
  localparam int UART_MAX_BITS = 16;

  // Odd parity over data+parity: the parity bit is the XNOR-reduction of the data.
  function automatic logic uart_parity(input logic [UART_MAX_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the value presented during and right after reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second filters it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame on the wire: START(0), PARITY, D0..D(DATA_BITS-1) LSB first, STOP(1).
// Received bytes are held on a valid/ready output register together with their
// parity/framing flags; a sticky overrun flag records bytes lost to a stalled consumer.
// Build option: define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3 vote of
// the samples at ticks mid-1, mid, mid+1 (decision at mid+1) instead of one mid sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_OFS = 1;
`else
  localparam int MAJ_OFS = 0;
`endif

  // Start-bit check lands half a bit after detection; every later decision is a
  // full bit after the previous one. The vote variant shifts all decisions by one tick.
  localparam logic [TCW-1:0] START_LAST = TCW'(OVERSAMPLE/2 - 1 + MAJ_OFS);
  localparam logic [TCW-1:0] BIT_LAST   = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 bit_val;
  uart_rx_state_t       state_q, state_d;
  logic [TCW-1:0]       tick_cnt;
  logic [TCW-1:0]       tick_last;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 p_rx;
  logic                 armed;
  logic                 at_last;
  logic                 do_start, glitch, take_par, take_data, take_stop;

  uart_sync2 #(.RST_VAL(UART_STOP_BIT)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Keep the two previous tick samples so the decision tick sees three in a row.
  always_ff @(posedge clk) begin
    if (rst)              hist <= 2'b11;
    else if (sample_tick) hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign tick_last = (state_q == START) ? START_LAST : BIT_LAST;
  assign at_last   = sample_tick && (tick_cnt == tick_last);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus one-cycle strobes telling the datapath which bit was just decided.
  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    glitch    = 1'b0;
    take_par  = 1'b0;
    take_data = 1'b0;
    take_stop = 1'b0;
    case (state_q)
      IDLE: begin
        // armed blocks a held-low (break) line from spawning frame after frame
        if (sample_tick && armed && (rx_s == UART_START_BIT)) begin
          state_d  = START;
          do_start = 1'b1;
        end
      end
      START: begin
        if (at_last) begin
          if (bit_val != UART_START_BIT) begin
            state_d = IDLE;
            glitch  = 1'b1;
          end else begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (at_last) begin
          state_d  = DATA;
          take_par = 1'b1;
        end
      end
      DATA: begin
        if (at_last) begin
          take_data = 1'b1;
          if (bit_cnt == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        // leaving at mid-stop leaves half a bit to catch a back-to-back start edge
        if (at_last) begin
          state_d   = IDLE;
          take_stop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tick/bit counters, shift register, parity capture and the idle-high re-arm flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      p_rx      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      if (do_start || at_last)                   tick_cnt <= '0;
      else if (sample_tick && (state_q != IDLE)) tick_cnt <= tick_cnt + 1'b1;

      if (take_par) begin
        p_rx    <= bit_val;
        bit_cnt <= '0;
      end else if (take_data) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (take_data) shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};

      if (rx_s == UART_STOP_BIT) armed <= 1'b1;
      if (do_start)              armed <= 1'b0;
      // a low stop bit means the line may be stuck; wait for it to go high again
      if (take_stop && (bit_val != UART_STOP_BIT)) armed <= 1'b0;
    end
  end

  // Output register: a completed frame always lands, even over an unread byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (do_start)                busy <= 1'b1;
      else if (glitch || take_stop) busy <= 1'b0;

      if (take_stop) begin
        data_out   <= shift_reg;
        parity_err <= (p_rx != uart_parity(UART_MAX_BITS'(shift_reg)));
        frame_err  <= (bit_val != UART_STOP_BIT);
        out_valid  <= 1'b1;
        // same-cycle handshake drains the old byte, so that case is not a loss
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (OVERSAMPLE=16, DATA_BITS=8).
// A free-running tick every TDIV clocks; frames are driven bit by bit and every
// valid/ready transfer is logged and compared against a frame-level model.
module tb_uart_rx;

  localparam int OS   = 16;
  localparam int TDIV = 3;
  localparam int BT   = OS * TDIV;   // clocks per bit

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx;
  logic [7:0] data_out;
  logic       out_valid, out_ready, parity_err, frame_err, overrun, busy;

  logic line = 1'b1;
  logic inv  = 1'b0;
  assign rx = line ^ inv;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx         (rx),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Baud tick generator.
  initial begin
    int cnt;
    cnt = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      sample_tick = (cnt == 0);
      cnt = (cnt + 1) % TDIV;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;
  rec_t rq[$];

  // Transfer log: sampled just before the edge that performs the handshake.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #4;
      if (out_valid && out_ready) begin
        r.d = data_out; r.pe = parity_err; r.fe = frame_err;
        rq.push_back(r);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (BT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    drive_bit(p);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(s);
    line = 1'b1;
  endtask

  // Model: odd total ones over data+parity, framing error iff stop was low.
  function automatic logic model_pe(input logic [7:0] d, input logic p);
    int ones;
    ones = p;
    for (int i = 0; i < 8; i++) ones += d[i];
    return (ones % 2) == 0;
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return (ones % 2) == 0;
  endfunction

  task automatic expect_one(input string nm, input logic [7:0] d, input logic pe, input logic fe);
    rec_t r;
    chk({nm, ".count"}, rq.size(), 1);
    if (rq.size() > 0) begin
      r = rq.pop_front();
      chk({nm, ".data"}, r.d, d);
      chk({nm, ".perr"}, r.pe, pe);
      chk({nm, ".ferr"}, r.fe, fe);
    end
    rq.delete();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  // Watchdog.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    logic [7:0] d;
    logic p, s;
    logic seen;

    vt[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    vt[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[4] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};

    rst = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.data_out", data_out, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.parity_err", parity_err, 0);
    chk("rst.frame_err", frame_err, 0);
    chk("rst.overrun", overrun, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    repeat (BT) @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      send_frame(vt[i].d, vt[i].p, vt[i].s);
      expect_one($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_pe, vt[i].exp_fe);
      repeat (BT) @(negedge clk);
    end
    chk("vec.overrun", overrun, 0);

    // Random frames, back to back unless the stop bit was low.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      p = good_par(d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 5) != 0);
      send_frame(d, p, s);
      expect_one($sformatf("rnd%0d", i), d, model_pe(d, p), !s);
      if (!s) repeat (BT) @(negedge clk);
    end

    // Short low glitch on an idle line.
    seen = 1'b0;
    line = 1'b0;
    repeat (4 * TDIV) @(negedge clk);
    line = 1'b1;
    for (int c = 0; c < 2 * BT; c++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("glitch.busy_seen", seen, 1);
    chk("glitch.busy_end", busy, 0);
    chk("glitch.no_frame", rq.size(), 0);
    rq.delete();

    // Break: stop bit low then line held low for 30 bit times.
    send_frame(8'h55, 1'b1, 1'b0);
    line = 1'b0;
    expect_one("brk.frame", 8'h55, 1'b0, 1'b1);
    repeat (30 * BT) @(negedge clk);
    chk("brk.no_repeat", rq.size(), 0);
    chk("brk.busy", busy, 0);
    line = 1'b1;
    repeat (2 * BT) @(negedge clk);
    chk("brk.idle_quiet", rq.size(), 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    expect_one("brk.recover", 8'h5A, 1'b0, 1'b0);
    repeat (BT) @(negedge clk);

    // Overrun: two frames with the consumer stalled.
    out_ready = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    chk("ovr.valid", out_valid, 1);
    chk("ovr.data", data_out, 8'hFF);
    chk("ovr.flag", overrun, 1);
    chk("ovr.perr", parity_err, 0);
    chk("ovr.none_taken", rq.size(), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk("ovr.valid_drop", out_valid, 0);
    chk("ovr.sticky", overrun, 1);
    expect_one("ovr.taken", 8'hFF, 1'b0, 1'b0);
    out_ready = 1'b1;

    // Reset in the middle of the data bits of 0x81.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    line = 1'b0;
    repeat (BT / 2) @(negedge clk);
    chk("rstmid.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.overrun", overrun, 0);
    chk("rstmid.valid", out_valid, 0);
    line = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BT) @(negedge clk);
    chk("rstmid.no_partial", rq.size(), 0);
    send_frame(8'h7E, 1'b1, 1'b1);
    expect_one("rstmid.clean", 8'h7E, 1'b0, 1'b0);
    repeat (BT) @(negedge clk);

`ifdef UART_RX_MAJORITY_EN
    // One-tick inversion at the mid sample of D3 must be outvoted.
    fork
      send_frame(8'hC3, 1'b1, 1'b1);
      begin
        int c;
        c = 0;
        while (!busy && c < 2 * BT) begin
          @(posedge clk); #1;
          c++;
        end
        chk("maj.start_seen", busy, 1);
        repeat (261) @(negedge clk);
        inv = 1'b1;
        repeat (3) @(negedge clk);
        inv = 1'b0;
      end
    join
    expect_one("maj.d3", 8'hC3, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
